instr_mem_fetch: RTL
====================

Name: instr_mem_fetch

Overview:
- Parametrised, clocked successor to the combinational instruction ROM.
- Synchronous single-port instruction store with a valid/ready fetch interface, configurable wait states and a flush input for taken branches/jumps.
- Includes a runtime program-load port; after reset, a hardware sweep fills the whole store with NOP.
- Sits between the PC/fetch stage and the decode stage of the RISC pipeline.

Parameters:
- ADDR_W, 14: PC/word-address width.
- DATA_W, 32: instruction width.
- DEPTH, 16384: implemented words; must be ≤ 2**ADDR_W.
- WAIT_STATES, 0: extra read cycles per fetch, range 0..7.
- NOP_WORD, 32'h0: fill and fault instruction, defaulting to the package NOP encoding.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_valid  in  1  fetch request.
- fetch_ready  out  1  request accepted when valid&ready.
- fetch_pc  in  ADDR_W  word address.
- flush  in  1  discard in-flight fetch.
- ir_valid  out  1  response valid.
- ir_ready  in  1  consumer accepts response.
- ir  out  DATA_W  fetched instruction.
- ir_fault  out  1  fetch_pc ≥ DEPTH.
- ld_valid  in  1  program-load write request.
- ld_ready  out  1  load accepted when valid&ready.
- ld_addr  in  ADDR_W  load word address.
- ld_data  in  DATA_W  load word.
- init_done  out  1  NOP sweep complete.

Behaviour:
- Reset (asynchronous, active-high)
  - Outputs: fetch_ready=0, ld_ready=0, ir_valid=0, ir=NOP_WORD, ir_fault=0, init_done=0.
  - State goes to CLEAR and the sweep counter goes to 0.
- Reset mid-operation
  - Aborts any fetch, load or sweep.
  - Store contents are lost; the sweep restarts from 0.
- CLEAR
  - Writes NOP_WORD to address cnt each cycle, cnt=0..DEPTH-1, i.e. DEPTH cycles.
  - On the final write: init_done=1 (sticky until reset), go to IDLE.
  - Fetch and load are both refused in this state.
- IDLE
  - fetch_ready = ld_ready = 1, except fetch_ready=0 when ld_valid=1 or flush=1.
  - Load has priority over fetch.
  - Load handshake: write RAM in the same cycle; stay in IDLE.
  - ld_addr ≥ DEPTH: handshake completes, write is dropped.
  - Fetch handshake: capture PC. If PC ≥ DEPTH, no RAM read; the response is NOP_WORD with ir_fault=1.
  - After a fetch: go to WAIT when WAIT_STATES>0, else to RESP.
- WAIT
  - A counter runs WAIT_STATES cycles, then the state moves to RESP.
- Latency
  - ir_valid rises exactly 1+WAIT_STATES cycles after the accepting edge.
- RESP
  - ir_valid=1; ir and ir_fault stay stable until ir_valid&ir_ready.
  - Then go to IDLE with ir_valid=0 next cycle.
  - No fetch is accepted in the same cycle as the response handshake, so at most one fetch is outstanding.
- flush
  - In WAIT or RESP: go to IDLE next cycle and drop ir_valid. The response is discarded even if ir_ready is asserted that cycle.
  - In IDLE: blocks fetch acceptance that cycle only.
  - In CLEAR: ignored.
- ld_ready=0 in WAIT and RESP; the RAM port is owned by the pending read.
- The ir register holds its last value while ir_valid=0.

Decomposition:
- Shared package holds:
  - Opcode and register field encodings, including NOP.
  - Default NOP_WORD.
  - State enum: CLEAR, IDLE, WAIT, RESP.
- Sub-module imem_ram: single-port synchronous RAM, DEPTH×DATA_W, with one read or one write per cycle and registered read data, no reset.
- The top level holds the FSM, sweep counter, wait counter, arbitration and fault logic.

Test Plan:
- Init sweep: DEPTH=64, WAIT_STATES=0, release reset → init_done rises after 64 cycles; fetch pc=5 → ir=NOP_WORD, ir_fault=0, ir_valid one cycle after acceptance.
- Load and fetch: WAIT_STATES=2, load addr 3 = 0xDEADBEEF, then fetch pc=3 → ir=0xDEADBEEF with ir_valid exactly 3 cycles after the fetch handshake.
- Backpressure: hold ir_ready=0 for 4 cycles during RESP → ir, ir_fault and ir_valid stable; fetch_ready=0 and ld_ready=0 throughout.
- Flush: WAIT_STATES=3, flush in the second WAIT cycle → no ir_valid; the next fetch of pc=3 returns 0xDEADBEEF normally.
- Fault and priority:
  - DEPTH=64, fetch pc=100 → ir=NOP_WORD, ir_fault=1.
  - ld_valid and fetch_valid in the same IDLE cycle → load accepted and fetch_ready=0; fetch accepted the next cycle.
- Reset mid-operation: assert reset during WAIT → ir_valid=0 immediately (asynchronous); after release init_done=0 and the sweep reruns, so the previously loaded addr 3 reads back NOP_WORD.

Source files
------------

// File: rtl/instr_mem_fetch_pkg.sv
// Shared encodings for the instruction fetch store: opcode/register fields,
// the NOP instruction and the fetch-controller state enum.
package instr_mem_fetch_pkg;

  localparam int OPC_W = 6;
  localparam int REG_W = 5;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP    = 6'h00,
    OP_ALU    = 6'h01,
    OP_ALUI   = 6'h02,
    OP_LOAD   = 6'h03,
    OP_STORE  = 6'h04,
    OP_BRANCH = 6'h05,
    OP_JUMP   = 6'h06
  } opcode_t;

  // Field layout: opcode[31:26] rs[25:21] rt[20:16] rd[15:11] funct[10:0]
  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;

  function automatic logic [31:0] mk_rtype(input opcode_t op, input logic [REG_W-1:0] rs,
                                           input logic [REG_W-1:0] rt,
                                           input logic [REG_W-1:0] rd);
    return {op, rs, rt, rd, 11'h000};
  endfunction

  localparam logic [31:0] NOP_INSTR = mk_rtype(OP_NOP, 5'd0, 5'd0, 5'd0);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } imf_state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous instruction RAM: one read or one write per cycle,
// registered read data that holds while the port is idle.
module imem_ram #(
  parameter int DEPTH  = 16384,
  parameter int DATA_W = 32,
  parameter int AW     = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/instr_mem_fetch.sv
// Clocked instruction store between PC/fetch and decode: NOP sweep after reset,
// program-load port, valid/ready fetch with wait states, flush and fault reporting.
module instr_mem_fetch
  import instr_mem_fetch_pkg::*;
#(
  parameter int                ADDR_W      = 14,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 16384,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] NOP_WORD    = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              flush,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir,
  output logic              ir_fault,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              init_done
);

  localparam int                RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0]        WS_LAST  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  imf_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [2:0]        wcnt;
  logic              fault_p0;
  logic              fetch_acc;
  logic              pc_oob, ld_oob;

  logic              ram_en, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign pc_oob = ({1'b0, fetch_pc} >= DEPTH_X);
  assign ld_oob = ({1'b0, ld_addr}  >= DEPTH_X);

  always_comb begin
    state_nxt   = state;
    fetch_ready = 1'b0;
    ld_ready    = 1'b0;
    fetch_acc   = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = ld_data;
    case (state)
      CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = cnt[RAM_AW-1:0];
        ram_wdata = NOP_WORD;
        if (cnt == CNT_LAST) state_nxt = IDLE;
      end
      IDLE: begin
        ld_ready    = 1'b1;
        fetch_ready = !ld_valid && !flush;
        if (ld_valid) begin
          // Out-of-range loads still handshake; only the write is suppressed
          ram_en   = !ld_oob;
          ram_we   = !ld_oob;
          ram_addr = ld_addr[RAM_AW-1:0];
        end else if (fetch_valid && !flush) begin
          fetch_acc = 1'b1;
          ram_en    = !pc_oob;
          ram_addr  = fetch_pc[RAM_AW-1:0];
          state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (flush)                 state_nxt = IDLE;
        else if (wcnt == WS_LAST)  state_nxt = RESP;
      end
      RESP: begin
        if (flush || (ir_valid && ir_ready)) state_nxt = IDLE;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Stage p0: request captured at the accepting edge; p1: response register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      cnt       <= '0;
      wcnt      <= '0;
      fault_p0  <= 1'b0;
      init_done <= 1'b0;
      ir_valid  <= 1'b0;
      ir        <= NOP_WORD;
      ir_fault  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) init_done <= 1'b1;
      end
      if (fetch_acc) begin
        fault_p0 <= pc_oob;
        wcnt     <= '0;
      end else if (state == WAIT) begin
        wcnt <= wcnt + 1'b1;
      end
      // RAM data is already registered on entry to RESP; first RESP cycle loads ir
      if (state == RESP) begin
        if (flush) begin
          ir_valid <= 1'b0;
        end else if (!ir_valid) begin
          ir_valid <= 1'b1;
          ir       <= fault_p0 ? NOP_WORD : ram_rdata;
          ir_fault <= fault_p0;
        end else if (ir_ready) begin
          ir_valid <= 1'b0;
        end
      end
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule
